// File: rtl/axi4_burst_slave_if.sv
// AXI4 bus bundle between an interconnect master port and the burst slave.
// Carries the five AXI4 channels (AW, W, B, AR, R) with their handshakes.
// Ports (via modports):
//   master : drives AW*/W*/AR* payload+VALID, BREADY, RREADY
//   slave  : drives AWREADY, WREADY, B* payload+VALID, ARREADY, R* payload+VALID
interface axi4_burst_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4
);
  localparam int NB = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic [NB-1:0]         WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;

  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi4_burst_slave.sv
// AXI4 memory-mapped leaf slave with its own word-organised storage.
// Supports FIXED/INCR/WRAP bursts, byte strobes and ID echo; read and write
// channels run independently with one outstanding burst each.
// Ports:
//   ACLK    : clock, rising edge
//   ARESETn : asynchronous active-low reset (memory contents are not reset)
//   axi     : AXI4 slave side (AW/W/B write path, AR/R read path)
module axi4_burst_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int ID_WIDTH     = 4,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  axi4_burst_slave_if.slave axi
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int SH = $clog2(NB);
  localparam int IW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (32'(addr) >> SH) < 32'(MEMORY_DEPTH);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IW'(addr >> SH);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step, total, lower, inc, res;
    step  = ADDR_WIDTH'(1) << size;
    total = ADDR_WIDTH'({1'b0, len} + 9'd1) << size;
    lower = addr & ~(total - ADDR_WIDTH'(1));
    inc   = addr + step;
    case (burst)
      2'b01:   res = inc;
      2'b10:   res = (inc == lower + total) ? lower : inc;
      default: res = addr;
    endcase
    return res;
  endfunction

  // Evaluated once at the address handshake; covers every SLVERR cause that
  // is knowable from the address phase alone.
  function automatic logic burst_err(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    logic [31:0] a, span, last;
    logic        e;
    a    = 32'(addr);
    span = 32'(len) << size;
    last = a + span;
    e    = 1'b0;
    if ((a >> SH) >= 32'(MEMORY_DEPTH)) e = 1'b1;
    if (32'(size) > 32'(SH))            e = 1'b1;
    case (burst)
      2'b00: ;
      2'b01: begin
        if ((a & 32'hFFF) + span > 32'hFFF)    e = 1'b1;
        if ((last >> SH) >= 32'(MEMORY_DEPTH)) e = 1'b1;
      end
      2'b10: begin
        if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}))    e = 1'b1;
        if ((a & ((32'd1 << size) - 32'd1)) != 32'd0) e = 1'b1;
      end
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // ---------------------------------------------------------------- write path
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t w_state, w_state_nxt;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic [ID_WIDTH-1:0]   w_id;
  logic [1:0]            w_resp;
  logic                  aw_hs, w_hs, w_last, wr_en, aw_err;

  assign aw_hs  = axi.AWVALID && (w_state == W_IDLE);
  assign w_hs   = axi.WVALID && (w_state == W_DATA);
  assign w_last = (w_cnt == 8'd0);
  assign wr_en  = w_hs && !w_err && in_range(w_addr);
  assign aw_err = burst_err(axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST);

  always_comb begin
    w_state_nxt = w_state;
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        axi.AWREADY = 1'b1;
        if (axi.AWVALID) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        axi.WREADY = 1'b1;
        // The burst ends on the beat count, regardless of WLAST.
        if (axi.WVALID && w_last) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        axi.BVALID = 1'b1;
        if (axi.BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      w_id    <= '0;
      w_resp  <= RESP_OKAY;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs) begin
        w_cnt  <= axi.AWLEN;
        w_err  <= aw_err;
        w_id   <= axi.AWID;
        w_resp <= aw_err ? RESP_SLVERR : RESP_OKAY;
      end else if (w_hs) begin
        w_cnt <= w_cnt - 8'd1;
        if (axi.WLAST != w_last) w_resp <= RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (aw_hs) begin
      w_addr  <= axi.AWADDR;
      w_len   <= axi.AWLEN;
      w_size  <= axi.AWSIZE;
      w_burst <= axi.AWBURST;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
    end
  end

  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (axi.WSTRB[b]) mem[word_idx(w_addr)][b*8 +: 8] <= axi.WDATA[b*8 +: 8];
      end
    end
  end

  assign axi.BID   = w_id;
  assign axi.BRESP = w_resp;

  // ----------------------------------------------------------------- read path
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  r_state_t r_state, r_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic                  ar_hs, r_hs, rd_fetch, rd_load, ar_err;

  assign ar_hs    = axi.ARVALID && (r_state == R_IDLE);
  assign r_hs     = axi.RREADY && (r_state == R_DATA);
  assign rd_fetch = (r_state == R_FETCH);
  // r_cnt holds the beats still to come after the one on the bus, so a
  // handshake with r_cnt != 0 reads the next word on the same edge.
  assign rd_load  = rd_fetch || (r_hs && (r_cnt != 8'd0));
  assign ar_err   = burst_err(axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST);

  always_comb begin
    r_state_nxt = r_state;
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        axi.ARREADY = 1'b1;
        if (axi.ARVALID) r_state_nxt = R_FETCH;
      end
      R_FETCH: r_state_nxt = R_DATA;
      R_DATA: begin
        axi.RVALID = 1'b1;
        if (axi.RREADY && (r_cnt == 8'd0)) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Registered read stage: RDATA/RRESP/RLAST only change on a load, so they
  // stay stable while RREADY is low.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_id    <= '0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
      r_last  <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        r_cnt <= axi.ARLEN;
        r_err <= ar_err;
        r_id  <= axi.ARID;
      end
      if (rd_load) begin
        r_data <= (r_err || !in_range(r_addr)) ? '0 : mem[word_idx(r_addr)];
        r_resp <= r_err ? RESP_SLVERR : RESP_OKAY;
        r_last <= rd_fetch ? (r_cnt == 8'd0) : (r_cnt == 8'd1);
        if (!rd_fetch) r_cnt <= r_cnt - 8'd1;
      end else if (r_hs) begin
        r_last <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ar_hs) begin
      r_addr  <= axi.ARADDR;
      r_len   <= axi.ARLEN;
      r_size  <= axi.ARSIZE;
      r_burst <= axi.ARBURST;
    end else if (rd_load) begin
      r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
    end
  end

  assign axi.RID   = r_id;
  assign axi.RDATA = r_data;
  assign axi.RRESP = r_resp;
  assign axi.RLAST = r_last;
endmodule

// File: tb/tb_axi4_burst_slave.sv
// Directed bench for axi4_burst_slave: a table of write/read bursts with
// hand-computed expectations, plus hand-written RREADY-stall and
// reset-mid-burst sequences.
module tb_axi4_burst_slave;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axi4_burst_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(4)) axi ();

  axi4_burst_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(4), .MEMORY_DEPTH(1024)
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .axi(axi.slave)
  );

  typedef struct {
    bit              wr;
    logic [15:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [3:0]      id;
    logic [3:0][31:0] dat;   // write data, or expected read data, per beat
    logic [3:0]      strb;
    logic [1:0]      resp;
    int              wl;     // beat index carrying WLAST
  } vec_t;

  int applied = 0;
  int miscompares = 0;
  vec_t vecs[19];

  function automatic vec_t mk(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                              input logic [31:0] d0, d1, d2, d3,
                              input logic [3:0] strb, input logic [1:0] resp, input int wl);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.id = id;
    v.dat = {d3, d2, d1, d0};
    v.strb = strb; v.resp = resp; v.wl = wl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check("rst_awready", 32'(axi.AWREADY), 32'd1);
    check("rst_arready", 32'(axi.ARREADY), 32'd1);
    check("rst_wready",  32'(axi.WREADY),  32'd0);
    check("rst_bvalid",  32'(axi.BVALID),  32'd0);
    check("rst_bresp",   32'(axi.BRESP),   32'd0);
    check("rst_bid",     32'(axi.BID),     32'd0);
    check("rst_rvalid",  32'(axi.RVALID),  32'd0);
    check("rst_rresp",   32'(axi.RRESP),   32'd0);
    check("rst_rlast",   32'(axi.RLAST),   32'd0);
    check("rst_rdata",   axi.RDATA,        32'd0);
    check("rst_rid",     32'(axi.RID),     32'd0);
  endtask

  task automatic do_write(input vec_t v);
    int cyc;
    axi.AWID = v.id; axi.AWADDR = v.addr; axi.AWLEN = v.len;
    axi.AWSIZE = v.size; axi.AWBURST = v.burst; axi.AWVALID = 1'b1;
    cyc = 0;
    while (!axi.AWREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
    check("awready_wait", 32'(axi.AWREADY), 32'd1);
    @(negedge ACLK);
    axi.AWVALID = 1'b0;
    check("wready_after_aw", 32'(axi.WREADY), 32'd1);
    for (int i = 0; i <= int'(v.len); i++) begin
      axi.WDATA = v.dat[i]; axi.WSTRB = v.strb; axi.WLAST = (i == v.wl); axi.WVALID = 1'b1;
      cyc = 0;
      while (!axi.WREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
      check("wready_wait", 32'(axi.WREADY), 32'd1);
      @(negedge ACLK);
    end
    axi.WVALID = 1'b0; axi.WLAST = 1'b0;
    check("bvalid_after_last", 32'(axi.BVALID), 32'd1);
    axi.BREADY = 1'b1;
    check("bresp", 32'(axi.BRESP), 32'(v.resp));
    check("bid",   32'(axi.BID),   32'(v.id));
    @(negedge ACLK);
    axi.BREADY = 1'b0;
    check("bvalid_cleared", 32'(axi.BVALID), 32'd0);
    check("awready_after_b", 32'(axi.AWREADY), 32'd1);
  endtask

  // pat[cyc%4] is the RREADY value driven in each data cycle of the burst.
  task automatic do_read(input vec_t v, input logic [3:0] pat);
    int cyc;
    int beat;
    logic rr;
    axi.ARID = v.id; axi.ARADDR = v.addr; axi.ARLEN = v.len;
    axi.ARSIZE = v.size; axi.ARBURST = v.burst; axi.ARVALID = 1'b1;
    cyc = 0;
    while (!axi.ARREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
    check("arready_wait", 32'(axi.ARREADY), 32'd1);
    @(negedge ACLK);
    axi.ARVALID = 1'b0;
    check("rvalid_during_fetch", 32'(axi.RVALID), 32'd0);
    check("arready_busy", 32'(axi.ARREADY), 32'd0);
    @(negedge ACLK);
    beat = 0;
    cyc = 0;
    while (beat <= int'(v.len) && cyc < 64) begin
      rr = pat[cyc % 4];
      axi.RREADY = rr;
      check("rvalid",  32'(axi.RVALID), 32'd1);
      check("rdata",   axi.RDATA, v.dat[beat]);
      check("rresp",   32'(axi.RRESP), 32'(v.resp));
      check("rid",     32'(axi.RID), 32'(v.id));
      check("rlast",   32'(axi.RLAST), 32'(beat == int'(v.len)));
      if (rr) beat++;
      @(negedge ACLK);
      cyc++;
    end
    axi.RREADY = 1'b0;
    check("rvalid_end",  32'(axi.RVALID), 32'd0);
    check("arready_end", 32'(axi.ARREADY), 32'd1);
  endtask

  initial begin
    int cyc;
    axi.AWID = '0; axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWBURST = '0; axi.AWVALID = 1'b0;
    axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b0;
    axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0; axi.ARBURST = '0; axi.ARVALID = 1'b0;
    axi.RREADY = 1'b0;

    //                wr  addr      len size burst  id  d0            d1            d2            d3            strb   resp   wl
    vecs[0]  = mk(1, 16'h0010, 0, 2, 2'b01, 3, 32'hDEADBEEF, 0,            0,            0,            4'hF, 2'b00, 0);
    vecs[1]  = mk(0, 16'h0010, 0, 2, 2'b01, 5, 32'hDEADBEEF, 0,            0,            0,            4'hF, 2'b00, 0);
    vecs[2]  = mk(1, 16'h0100, 3, 2, 2'b01, 1, 1,            2,            3,            4,            4'hF, 2'b00, 3);
    vecs[3]  = mk(1, 16'h0030, 3, 2, 2'b01, 6, 32'hA0A0A0A0, 32'hB0B0B0B0, 32'hC0C0C0C0, 32'hD0D0D0D0, 4'hF, 2'b00, 3);
    vecs[4]  = mk(0, 16'h0038, 3, 2, 2'b10, 2, 32'hC0C0C0C0, 32'hD0D0D0D0, 32'hA0A0A0A0, 32'hB0B0B0B0, 4'hF, 2'b00, 3);
    vecs[5]  = mk(1, 16'h0200, 0, 2, 2'b01, 4, 32'h11223344, 0,            0,            0,            4'hF, 2'b00, 0);
    vecs[6]  = mk(1, 16'h0200, 0, 2, 2'b01, 4, 32'hAABBCCDD, 0,            0,            0,            4'h5, 2'b00, 0);
    vecs[7]  = mk(0, 16'h0200, 0, 2, 2'b01, 8, 32'h11BB33DD, 0,            0,            0,            4'hF, 2'b00, 0);
    vecs[8]  = mk(1, 16'h0FF8, 1, 2, 2'b01, 1, 32'h5555AAAA, 32'h12345678, 0,            0,            4'hF, 2'b00, 1);
    vecs[9]  = mk(1, 16'h0FF8, 3, 2, 2'b01, 2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 2'b10, 3);
    vecs[10] = mk(0, 16'h0FF8, 1, 2, 2'b01, 3, 32'h5555AAAA, 32'h12345678, 0,            0,            4'hF, 2'b00, 1);
    vecs[11] = mk(0, 16'h1000, 0, 2, 2'b01, 9, 0,            0,            0,            0,            4'hF, 2'b10, 0);
    vecs[12] = mk(1, 16'h0010, 0, 2, 2'b11, 7, 32'hFFFFFFFF, 0,            0,            0,            4'hF, 2'b10, 0);
    vecs[13] = mk(0, 16'h0010, 0, 2, 2'b01, 12, 32'hDEADBEEF, 0,           0,            0,            4'hF, 2'b00, 0);
    vecs[14] = mk(1, 16'h0500, 3, 2, 2'b01, 13, 1,           2,            3,            4,            4'hF, 2'b10, 1);
    vecs[15] = mk(1, 16'h0300, 2, 2, 2'b00, 14, 1,           2,            3,            0,            4'hF, 2'b00, 2);
    vecs[16] = mk(0, 16'h0300, 0, 2, 2'b00, 15, 3,           0,            0,            0,            4'hF, 2'b00, 0);
    vecs[17] = mk(0, 16'h0030, 2, 2, 2'b10, 6, 0,            0,            0,            0,            4'hF, 2'b10, 2);
    vecs[18] = mk(1, 16'h0400, 0, 3, 2'b01, 10, 32'h12121212, 0,           0,            0,            4'hF, 2'b10, 0);

    repeat (3) @(negedge ACLK);
    check_reset_values();
    ARESETn = 1'b1;
    @(negedge ACLK);
    check_reset_values();

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].wr) do_write(vecs[i]);
      else            do_read(vecs[i], 4'hF);
    end

    // INCR readback of 1..4 with RREADY toggling.
    do_read(mk(0, 16'h0100, 3, 2, 2'b01, 11, 1, 2, 3, 4, 4'hF, 2'b00, 3), 4'b0110);

    // Reset asserted while beat 2 of a read burst is on the bus.
    axi.ARID = 4'hA; axi.ARADDR = 16'h0100; axi.ARLEN = 8'd3;
    axi.ARSIZE = 3'd2; axi.ARBURST = 2'b01; axi.ARVALID = 1'b1;
    cyc = 0;
    while (!axi.ARREADY && cyc < 50) begin @(negedge ACLK); cyc++; end
    check("mid_arready", 32'(axi.ARREADY), 32'd1);
    @(negedge ACLK);
    axi.ARVALID = 1'b0;
    axi.RREADY = 1'b1;
    @(negedge ACLK);
    check("mid_beat1", axi.RDATA, 32'd1);
    @(negedge ACLK);
    check("mid_beat2", axi.RDATA, 32'd2);
    axi.RREADY = 1'b0;
    ARESETn = 1'b0;
    @(negedge ACLK);
    check_reset_values();
    ARESETn = 1'b1;
    @(negedge ACLK);
    check_reset_values();
    do_read(mk(0, 16'h0100, 0, 2, 2'b01, 4'hB, 1, 0, 0, 0, 4'hF, 2'b00, 0), 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
